clk_en_frac_multi: RTL and testbench

- Parametrised successor to the fixed integer clock-enable divider feeding the video and CPU domains.
- Generates CHANNELS independent fractional clock-enable pulse trains from clk_sys (rate = inc/den per channel).
- Supports a global speed divider (matching the OSD FDiv option: 1/1, 1/2, 1/3, stop) and a pause gate.
- Sits between the core top level and the CPU/sound/video sub-blocks; replaces per-block hard-coded dividers.

---
 rtl/clk_en_frac_multi.sv | 142 ++++++++++++++
 tb/tb_clk_en_frac_multi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_frac_multi.sv
// CHANNELS fractional clock-enable generators (rate inc/den each) behind a shared fdiv/pause gate.
// Define CLK_EN_FRAC_MULTI_STATS_EN to add per-channel saturating pulse counters (stat_clr/stat_cnt).
module clk_en_frac_multi #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [CHANNELS*ACC_W-1:0] inc_in,
  input  logic [CHANNELS*ACC_W-1:0] den_in,
  input  logic [1:0]                fdiv,
  input  logic                      pause,
`ifdef CLK_EN_FRAC_MULTI_STATS_EN
  input  logic                      stat_clr,
  output logic [CHANNELS*16-1:0]    stat_cnt,
`endif
  output logic [CHANNELS-1:0]       ce,
  output logic                      tick
);

  logic [1:0]          g_q, g_d;
  logic [1:0]          fdiv_q, fdiv_d;
  logic [1:0]          g_eff_s;
  logic                active_s;
  logic                adv_s;
  logic [ACC_W-1:0]    inc_q  [CHANNELS];
  logic [ACC_W-1:0]    inc_d  [CHANNELS];
  logic [ACC_W-1:0]    den_q  [CHANNELS];
  logic [ACC_W-1:0]    den_d  [CHANNELS];
  logic [ACC_W-1:0]    acc_q  [CHANNELS];
  logic [ACC_W-1:0]    acc_d  [CHANNELS];
  logic [ACC_W:0]      sum_s  [CHANNELS];
  logic [ACC_W-1:0]    diff_s [CHANNELS];
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic                tick_q, tick_d;

  // Advance gate: a newly seen fdiv value restarts the phase at zero so the new ratio starts at once.
  always_comb begin
    fdiv_d   = fdiv;
    g_eff_s  = (fdiv != fdiv_q) ? 2'd0 : g_q;
    active_s = !pause && (fdiv != 2'd3);
    adv_s    = active_s && (g_eff_s == 2'd0);
    tick_d   = adv_s;
    if (!active_s) begin
      g_d = g_eff_s;
    end else if (g_eff_s == fdiv) begin
      g_d = 2'd0;
    end else begin
      g_d = g_eff_s + 2'd1;
    end
  end

  // Per-channel accumulators; inc>=den or den==0 saturates to a pulse on every advance.
  always_comb begin
    ce_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      inc_d[k]  = inc_q[k];
      den_d[k]  = den_q[k];
      acc_d[k]  = acc_q[k];
      sum_s[k]  = {1'b0, acc_q[k]} + {1'b0, inc_q[k]};
      diff_s[k] = ACC_W'(sum_s[k] - {1'b0, den_q[k]});
      if (load) begin
        inc_d[k] = inc_in[k*ACC_W +: ACC_W];
        den_d[k] = den_in[k*ACC_W +: ACC_W];
        acc_d[k] = '0;
      end else if (!adv_s) begin
        acc_d[k] = acc_q[k];
      end else if ((den_q[k] == '0) || (inc_q[k] >= den_q[k])) begin
        acc_d[k] = '0;
        ce_d[k]  = 1'b1;
      end else if (sum_s[k] >= {1'b0, den_q[k]}) begin
        acc_d[k] = diff_s[k];
        ce_d[k]  = 1'b1;
      end else begin
        acc_d[k] = sum_s[k][ACC_W-1:0];
      end
    end
  end

  // State registers; reset leaves every channel at rate 0/1 so nothing pulses before a load.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      g_q    <= 2'd0;
      fdiv_q <= 2'd0;
      ce_q   <= '0;
      tick_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        inc_q[k] <= '0;
        den_q[k] <= ACC_W'(1);
        acc_q[k] <= '0;
      end
    end else begin
      g_q    <= g_d;
      fdiv_q <= fdiv_d;
      ce_q   <= ce_d;
      tick_q <= tick_d;
      for (int k = 0; k < CHANNELS; k++) begin
        inc_q[k] <= inc_d[k];
        den_q[k] <= den_d[k];
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign ce   = ce_q;
  assign tick = tick_q;

`ifdef CLK_EN_FRAC_MULTI_STATS_EN
  logic [15:0] cnt_q [CHANNELS];
  logic [15:0] cnt_d [CHANNELS];

  // Saturating pulse counters; clear or load takes priority over counting.
  always_comb begin
    stat_cnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (stat_clr || load) begin
        cnt_d[k] = 16'h0000;
      end else if (ce_q[k] && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end else begin
        cnt_d[k] = cnt_q[k];
      end
      stat_cnt[k*16 +: 16] = cnt_q[k];
    end
  end

  // Counter registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_clk_en_frac_multi.sv
// Bench for clk_en_frac_multi: a rational-rate reference (pulse when floor(n*inc/den) steps) checked
// every cycle, plus hand-computed literal checks. Stats checks build with CLK_EN_FRAC_MULTI_STATS_EN.
module tb_clk_en_frac_multi;
  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic            load    = 1'b0;
  logic [CH*W-1:0] inc_in  = '0;
  logic [CH*W-1:0] den_in  = '0;
  logic [1:0]      fdiv    = 2'd0;
  logic            pause   = 1'b0;
  logic [CH-1:0]   ce;
  logic            tick;
`ifdef CLK_EN_FRAC_MULTI_STATS_EN
  logic            stat_clr = 1'b0;
  logic [CH*16-1:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cnt [CH];
  int first [CH];
  int second [CH];
  int tot [CH];
  int ticks;

  always #5 clk_sys = ~clk_sys;

  clk_en_frac_multi #(.CHANNELS(CH), .ACC_W(W)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (load),
    .inc_in  (inc_in),
    .den_in  (den_in),
    .fdiv    (fdiv),
    .pause   (pause),
`ifdef CLK_EN_FRAC_MULTI_STATS_EN
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt),
`endif
    .ce      (ce),
    .tick    (tick)
  );

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: advances happen on every (fdiv+1)-th active cycle counted from the last
  // fdiv change; channel k pulses on advance n when floor(n*inc/den) increases.
  logic [CH-1:0]   exp_ce;
  logic            exp_tick;
  longint unsigned m_inc [CH];
  longint unsigned m_den [CH];
  longint unsigned m_n [CH];
  int              m_phase;
  logic [1:0]      m_prev;
  bit              m_active;
  bit              m_adv;

  function automatic bit rate_pulse(longint unsigned n, longint unsigned inc, longint unsigned den);
    if (den == 0 || inc >= den) return 1'b1;
    if (inc == 0) return 1'b0;
    return ((n * inc) / den) != (((n - 1) * inc) / den);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_inc[k] = 0;
      m_den[k] = 1;
      m_n[k]   = 0;
    end
    m_phase  = 0;
    m_prev   = 2'd0;
    exp_ce   = '0;
    exp_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        if (fdiv != m_prev) m_phase = 0;
        m_prev   = fdiv;
        m_active = !pause && (fdiv != 2'd3);
        m_adv    = m_active && ((m_phase % (int'(fdiv) + 1)) == 0);
        if (m_active) m_phase++;
        exp_tick = m_adv;
        for (int k = 0; k < CH; k++) begin
          if (load) begin
            m_inc[k]  = inc_in[k*W +: W];
            m_den[k]  = den_in[k*W +: W];
            m_n[k]    = 0;
            exp_ce[k] = 1'b0;
          end else if (m_adv) begin
            m_n[k]++;
            exp_ce[k] = rate_pulse(m_n[k], m_inc[k], m_den[k]);
          end else begin
            exp_ce[k] = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk_sys);
    @(posedge clk_sys);
    forever begin
      @(negedge clk_sys);
      check("ce_model", ce, exp_ce);
      check("tick_model", tick, exp_tick);
    end
  end

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic set_cfg(input logic [W-1:0] i0, input logic [W-1:0] d0, input logic [W-1:0] i1,
                         input logic [W-1:0] d1, input logic [W-1:0] i2, input logic [W-1:0] d2,
                         input logic [W-1:0] i3, input logic [W-1:0] d3);
    inc_in = {i3, i2, i1, i0};
    den_in = {d3, d2, d1, d0};
  endtask

  task automatic do_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run(input int ncyc);
    ticks = 0;
    for (int k = 0; k < CH; k++) begin
      cnt[k] = 0; first[k] = -1; second[k] = -1;
    end
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (tick) ticks++;
      for (int k = 0; k < CH; k++) begin
        if (ce[k]) begin
          cnt[k]++;
          tot[k]++;
          if (first[k] < 0) first[k] = i;
          else if (second[k] < 0) second[k] = i;
        end
      end
    end
  endtask

  function automatic int cnt_sum();
    return cnt[0] + cnt[1] + cnt[2] + cnt[3];
  endfunction

  initial begin
    step(); step(); step();
    check("reset_ce", ce, 0);
    check("reset_tick", tick, 0);
    reset_n = 1'b1;
    run(20);
    check("idle_no_ce", cnt_sum(), 0);
    check("idle_tick", ticks, 20);

    // Rates 1/8, 3/8, den=0, inc=den at full speed.
    set_cfg(16'd1, 16'd8, 16'd3, 16'd8, 16'd4, 16'd0, 16'd5, 16'd5);
    do_load();
    check("load_cycle_ce_a", ce, 0);
    for (int k = 0; k < CH; k++) tot[k] = 0;
    run(8);
    check("ch0_first", first[0], 8);
    check("ch1_cnt8", cnt[1], 3);
    check("ch1_first", first[1], 3);
    check("ch1_second", second[1], 6);
    run(792);
    check("ch0_800", tot[0], 100);
    run(7200);
    check("ch0_8000", tot[0], 1000);
    check("ch1_8000", tot[1], 3000);
    check("ch2_den0", tot[2], 8000);
    check("ch3_eq", tot[3], 8000);

    // fdiv=1 then 2 then stop then full speed, rate 1/2.
    set_cfg(16'd1, 16'd2, 16'd0, 16'd7, 16'd0, 16'd0, 16'd7, 16'd5);
    fdiv = 2'd1;
    do_load();
    check("load_cycle_ce_b", ce, 0);
    run(400);
    check("f1_first", first[0], 4);
    check("f1_period", second[0] - first[0], 4);
    check("f1_cnt0", cnt[0], 100);
    check("inc0_never", cnt[1], 0);
    check("f1_cnt2", cnt[2], 200);
    check("f1_cnt3", cnt[3], 200);
    check("f1_ticks", ticks, 200);
    fdiv = 2'd2;
    run(600);
    check("f2_first", first[0], 4);
    check("f2_period", second[0] - first[0], 6);
    check("f2_cnt0", cnt[0], 100);
    check("f2_cnt3", cnt[3], 200);
    check("f2_ticks", ticks, 200);
    fdiv = 2'd3;
    run(1000);
    check("stop_ce", cnt_sum(), 0);
    check("stop_ticks", ticks, 0);
    fdiv = 2'd0;
    run(20);
    check("resume_first", first[0], 2);
    check("resume_cnt", cnt[0], 10);

    // Pause with ch0 accumulator at 5 of 8.
    set_cfg(16'd1, 16'd8, 16'd3, 16'd8, 16'd0, 16'd7, 16'd5, 16'd5);
    do_load();
    run(5);
    check("pre_pause_ch0", cnt[0], 0);
    pause = 1'b1;
    run(37);
    check("pause_ce", cnt_sum(), 0);
    check("pause_ticks", ticks, 0);
    pause = 1'b0;
    run(10);
    check("post_pause_first", first[0], 3);
    check("post_pause_ch3", cnt[3], 10);
    check("ch2_inc0_never", cnt[2], 0);

    // Load while paused, rate 2/3.
    pause = 1'b1;
    set_cfg(16'd2, 16'd3, 16'd1, 16'd1, 16'd0, 16'd7, 16'd5, 16'd5);
    do_load();
    run(10);
    check("load_pause_ce", cnt_sum(), 0);
    pause = 1'b0;
    run(9);
    check("r23_first", first[0], 2);
    check("r23_cnt", cnt[0], 6);
    check("r11_cnt", cnt[1], 9);

    // Asynchronous reset mid-operation.
    check("pre_reset_ce3", ce[3], 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_ce", ce, 0);
    check("async_reset_tick", tick, 0);
    step(); step();
    reset_n = 1'b1;
    run(30);
    check("post_reset_ce", cnt_sum(), 0);
    check("post_reset_ticks", ticks, 30);

`ifdef CLK_EN_FRAC_MULTI_STATS_EN
    set_cfg(16'd1, 16'd8, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1);
    do_load();
    run(81);
    check("stat_10", stat_cnt[15:0], 10);
    check("stat_ch1_0", stat_cnt[31:16], 0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_clr", stat_cnt[15:0], 0);
    set_cfg(16'd1, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1);
    do_load();
    run(70000);
    check("stat_sat", stat_cnt[15:0], 65535);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
